medidor_frequencia: RTL

Measures an external slow square-wave signal against the fast system clock. This is the inverse of the clock divider: that block produces a slow clock, and this block recovers its frequency (rising edges per gate window) and its period (system cycles between consecutive rising edges). It sits beside the divider for self-check of the divided clock, and serves any board-level slow input (sensor pulse, encoder). Results go to display/control logic with one-cycle valid strobes.

---
 rtl/medidor_frequencia_pkg.sv | 19 +
 rtl/medidor_frequencia_if.sv | 35 +++
 rtl/medidor_frequencia_sincronizador_borda.sv | 40 ++++
 rtl/medidor_frequencia.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/medidor_frequencia_pkg.sv
// ---------------------------------------------------------------------------
// medidor_frequencia_pkg
// Shared definitions for the frequency/period meter and its companion clock
// divider: period-FSM state encodings and default timing constants.
// ---------------------------------------------------------------------------
package medidor_frequencia_pkg;

  // Period measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } estado_t;

  // System clock frequency and the matching 1-second gate length
  localparam int CLK_HZ  = 50_000_000;
  localparam int GATE_1S = CLK_HZ;

endpackage

// File: rtl/medidor_frequencia_if.sv
// ---------------------------------------------------------------------------
// medidor_frequencia_if
// Control/result bundle of the frequency meter.
//   ENABLE       measure request (1 = measure, 0 = idle)
//   SIG_IN       asynchronous signal under measurement
//   FREQ         rising edges in the last complete gate window
//   FREQ_VALID   one-cycle strobe when FREQ updates
//   PERIOD       clock cycles between the last two rising edges
//   PERIOD_VALID one-cycle strobe when PERIOD updates
//   NO_SIGNAL    last complete window counted zero edges
// master: the user side (drives ENABLE/SIG_IN, reads results)
// slave : the meter itself
// ---------------------------------------------------------------------------
interface medidor_frequencia_if #(
  parameter int CNT_W = 26,
  parameter int PER_W = 26
);
  logic             ENABLE;
  logic             SIG_IN;
  logic [CNT_W-1:0] FREQ;
  logic             FREQ_VALID;
  logic [PER_W-1:0] PERIOD;
  logic             PERIOD_VALID;
  logic             NO_SIGNAL;

  modport master (
    output ENABLE, SIG_IN,
    input  FREQ, FREQ_VALID, PERIOD, PERIOD_VALID, NO_SIGNAL
  );

  modport slave (
    input  ENABLE, SIG_IN,
    output FREQ, FREQ_VALID, PERIOD, PERIOD_VALID, NO_SIGNAL
  );
endinterface

// File: rtl/medidor_frequencia_sincronizador_borda.sv
// ---------------------------------------------------------------------------
// sincronizador_borda
// Two-flop synchronizer for an asynchronous input followed by a history flop
// for rising-edge detection. Reusable for buttons and other async inputs.
//   CLOCK  system clock (posedge)
//   RESET  synchronous, active-high; clears all three flops
//   D      asynchronous input
//   Q_SYNC synchronized level (second flop)
//   RISE   one-cycle pulse: synchronized level went 0 -> 1
// D first sampled high at edge k gives RISE high between edges k+1 and k+2,
// so a consumer registering on RISE acts at edge k+2.
// ---------------------------------------------------------------------------
module sincronizador_borda (
  input  logic CLOCK,
  input  logic RESET,
  input  logic D,
  output logic Q_SYNC,
  output logic RISE
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= D;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign Q_SYNC = r_s2;
  assign RISE   = r_s2 & ~r_s3;

endmodule

// File: rtl/medidor_frequencia.sv
// ---------------------------------------------------------------------------
// medidor_frequencia
// Measures a slow external square wave against the system clock:
//   - frequency: rising edges counted over a gate of GATE_CYCLES clocks
//   - period   : clock cycles between consecutive rising edges
// Ports:
//   CLOCK  system clock, all logic on posedge
//   RESET  synchronous, active-high
//   bus    medidor_frequencia_if.slave (ENABLE, SIG_IN in; results out)
// Measurement is active only once the period FSM has left IDLE, so every
// enable (including after reset) costs one IDLE->ARMED cycle before the
// first gate cycle is counted. The synchronizer runs regardless of ENABLE so
// a signal already high at enable is not seen as an edge.
// ---------------------------------------------------------------------------
module medidor_frequencia
  import medidor_frequencia_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_1S,
  parameter int CNT_W       = 26,
  parameter int PER_W       = 26
) (
  input logic                 CLOCK,
  input logic                 RESET,
  medidor_frequencia_if.slave bus
);

  localparam int            GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  // Edge count plus an optional extra edge, stuck at all-ones
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                   input logic             inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  logic             w_rise;
  logic             w_sync_unused;
  logic             w_active;
  logic             w_close;
  logic [CNT_W-1:0] w_freq_fim;

  estado_t          r_state;
  estado_t          w_next_state;
  logic [PER_W-1:0] w_per_cnt_nxt;
  logic             w_per_load;

  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_freq;
  logic             r_freq_valid;
  logic             r_no_signal;
  logic [PER_W-1:0] r_per_cnt;
  logic [PER_W-1:0] r_period;
  logic             r_period_valid;

  sincronizador_borda u_sinc (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .D      (bus.SIG_IN),
    .Q_SYNC (w_sync_unused),
    .RISE   (w_rise)
  );

  // ---- gate window / edge counting ----
  assign w_active   = bus.ENABLE && (r_state != ST_IDLE);
  assign w_close    = w_active && (r_gate_cnt == GATE_LAST);
  // A rise in the closing cycle belongs to the window being closed
  assign w_freq_fim = sat_inc_cnt(r_edge_cnt, w_rise);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_freq       <= '0;
      r_freq_valid <= 1'b0;
      r_no_signal  <= 1'b0;
    end else if (!w_active) begin
      // Partial window is discarded; results hold
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_freq_valid <= 1'b0;
    end else if (w_close) begin
      r_freq       <= w_freq_fim;
      r_no_signal  <= (w_freq_fim == '0);
      r_freq_valid <= 1'b1;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
    end else begin
      r_gate_cnt   <= r_gate_cnt + GW'(1);
      r_edge_cnt   <= w_freq_fim;
      r_freq_valid <= 1'b0;
    end
  end

  // ---- period FSM: state register ----
  always_ff @(posedge CLOCK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // ---- period FSM: next state ----
  always_comb begin
    w_next_state = r_state;
    if (!bus.ENABLE) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_next_state = ST_ARMED;
        ST_ARMED:   if (w_rise) w_next_state = ST_MEASURE;
        ST_MEASURE: begin
          // No edge within the counter range: give up and re-arm
          if (!w_rise && (r_per_cnt == {PER_W{1'b1}}))
            w_next_state = ST_ARMED;
        end
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  // ---- period FSM: outputs ----
  always_comb begin
    w_per_cnt_nxt = '0;
    w_per_load    = 1'b0;
    if (bus.ENABLE) begin
      case (r_state)
        ST_ARMED: begin
          if (w_rise) w_per_cnt_nxt = PER_W'(1);
        end
        ST_MEASURE: begin
          if (w_rise) begin
            w_per_load    = 1'b1;
            w_per_cnt_nxt = PER_W'(1);
          end else if (r_per_cnt != {PER_W{1'b1}}) begin
            w_per_cnt_nxt = r_per_cnt + PER_W'(1);
          end
        end
        default: w_per_cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_per_cnt      <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_per_cnt      <= w_per_cnt_nxt;
      r_period_valid <= w_per_load;
      if (w_per_load) r_period <= r_per_cnt;
    end
  end

  assign bus.FREQ         = r_freq;
  assign bus.FREQ_VALID   = r_freq_valid;
  assign bus.NO_SIGNAL    = r_no_signal;
  assign bus.PERIOD       = r_period;
  assign bus.PERIOD_VALID = r_period_valid;

endmodule
